// File: rtl/dualram_arbiter.sv
// dualram_arbiter
// Shares the X and Y ports of a dual-port RAM among NREQ requesters.
// Up to two requests are granted per cycle in round-robin order: the first
// winner drives port X, the second drives port Y. A second winner that
// touches the first winner's address, where either of them writes, is held
// back for a later cycle. Port ownership tags travel two stages behind each
// grant so that registered read data reaches the requester that asked for it.

module dualram_arbiter #(
    parameter int W    = 16,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*W-1:0] req_addr,
    input  logic [NREQ*W-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [NREQ*W-1:0] rdata,
    output logic [W-1:0]      ram_addr_x,
    output logic [W-1:0]      ram_addr_y,
    output logic [W-1:0]      ram_data_x,
    output logic [W-1:0]      ram_data_y,
    output logic              ram_we_x,
    output logic              ram_we_y,
    input  logic [W-1:0]      ram_q_x,
    input  logic [W-1:0]      ram_q_y
);

    localparam int PW  = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    typedef logic [PW-1:0] idx_t;

    // Round-robin successor of a requester index.
    function automatic idx_t next_idx(input idx_t i);
        if (i == idx_t'(NREQ - 1)) begin
            return idx_t'(0);
        end else begin
            return i + idx_t'(1);
        end
    endfunction

    // Single-bit mask selecting one requester.
    function automatic logic [NREQ-1:0] onehot(input idx_t i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [NREQ*W-1:0] rdata_q,  rdata_d;
    idx_t              rr_ptr_q, rr_ptr_d;

    logic [W-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
    logic [W-1:0] data_x_q, data_x_d, data_y_q, data_y_d;
    logic         we_x_q,   we_x_d,   we_y_q,   we_y_d;

    // Port tags: stage 1 follows the grant edge, stage 2 the RAM execute edge.
    logic tx1_rd_q, tx1_rd_d, ty1_rd_q, ty1_rd_d;
    idx_t tx1_own_q, tx1_own_d, ty1_own_q, ty1_own_d;
    logic tx2_rd_q, ty2_rd_q;
    idx_t tx2_own_q, ty2_own_q;

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    logic [NREQ-1:0] elig_s;
    logic [PW1-1:0]  scan_sum_s, scan_s;
    logic            found_a_s, found_b_s;
    idx_t            idx_a_s, idx_b_s;
    logic [W-1:0]    addr_a_s, addr_b_s, wdata_a_s, wdata_b_s;
    logic            we_a_s, we_b_s;
    logic            hazard_s, grant_b_s;

    // A requester granted last cycle is still showing its old request.
    assign elig_s = req & ~gnt_q;

    // Scan eligible requesters from rr_ptr upward and pick the first two hits.
    always_comb begin
        found_a_s  = 1'b0;
        found_b_s  = 1'b0;
        idx_a_s    = idx_t'(0);
        idx_b_s    = idx_t'(0);
        scan_sum_s = '0;
        scan_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum_s = {1'b0, rr_ptr_q} + PW1'(k);
            scan_s     = (scan_sum_s >= PW1'(NREQ)) ? (scan_sum_s - PW1'(NREQ)) : scan_sum_s;
            if (elig_s[scan_s[PW-1:0]] && !found_a_s) begin
                found_a_s = 1'b1;
                idx_a_s   = scan_s[PW-1:0];
            end else if (elig_s[scan_s[PW-1:0]] && !found_b_s) begin
                found_b_s = 1'b1;
                idx_b_s   = scan_s[PW-1:0];
            end else begin
                // idle slot or a third hit: it waits for a later scan
                found_b_s = found_b_s;
            end
        end
    end

    assign addr_a_s  = req_addr[idx_a_s*W +: W];
    assign addr_b_s  = req_addr[idx_b_s*W +: W];
    assign wdata_a_s = req_wdata[idx_a_s*W +: W];
    assign wdata_b_s = req_wdata[idx_b_s*W +: W];
    assign we_a_s    = req_we[idx_a_s];
    assign we_b_s    = req_we[idx_b_s];

    // Same address with a write on either side must not share a cycle;
    // read-read to one address is harmless.
    assign hazard_s  = found_b_s && (addr_a_s == addr_b_s) && (we_a_s || we_b_s);
    assign grant_b_s = found_b_s && !hazard_s;

    // Next-state for grants, RAM port registers, pointer and stage-1 tags.
    always_comb begin
        gnt_d     = '0;
        rr_ptr_d  = rr_ptr_q;
        addr_x_d  = addr_x_q;
        data_x_d  = data_x_q;
        we_x_d    = 1'b0;
        addr_y_d  = addr_y_q;
        data_y_d  = data_y_q;
        we_y_d    = 1'b0;
        tx1_rd_d  = 1'b0;
        tx1_own_d = idx_a_s;
        ty1_rd_d  = 1'b0;
        ty1_own_d = idx_b_s;
        if (found_a_s) begin
            gnt_d    = gnt_d | onehot(idx_a_s);
            addr_x_d = addr_a_s;
            data_x_d = wdata_a_s;
            we_x_d   = we_a_s;
            tx1_rd_d = !we_a_s;
            rr_ptr_d = next_idx(idx_a_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (grant_b_s) begin
            gnt_d    = gnt_d | onehot(idx_b_s);
            addr_y_d = addr_b_s;
            data_y_d = wdata_b_s;
            we_y_d   = we_b_s;
            ty1_rd_d = !we_b_s;
            rr_ptr_d = next_idx(idx_b_s);
        end else begin
            we_y_d = 1'b0;
        end
    end

    // Read return: RAM data for a read appears two edges after its grant.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tx2_rd_q) begin
            rvalid_d[tx2_own_q]        = 1'b1;
            rdata_d[tx2_own_q*W +: W]  = ram_q_x;
        end else begin
            rvalid_d = rvalid_d;
        end
        if (ty2_rd_q) begin
            rvalid_d[ty2_own_q]        = 1'b1;
            rdata_d[ty2_own_q*W +: W]  = ram_q_y;
        end else begin
            rvalid_d = rvalid_d;
        end
    end

    // Grant pulses, round-robin pointer and RAM port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            rr_ptr_q <= idx_t'(0);
            addr_x_q <= '0;
            data_x_q <= '0;
            we_x_q   <= 1'b0;
            addr_y_q <= '0;
            data_y_q <= '0;
            we_y_q   <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            addr_x_q <= addr_x_d;
            data_x_q <= data_x_d;
            we_x_q   <= we_x_d;
            addr_y_q <= addr_y_d;
            data_y_q <= data_y_d;
            we_y_q   <= we_y_d;
        end
    end

    // Two-stage owner/is-read tags alongside each port; reset drops in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx1_rd_q  <= 1'b0;
            tx1_own_q <= idx_t'(0);
            ty1_rd_q  <= 1'b0;
            ty1_own_q <= idx_t'(0);
            tx2_rd_q  <= 1'b0;
            tx2_own_q <= idx_t'(0);
            ty2_rd_q  <= 1'b0;
            ty2_own_q <= idx_t'(0);
        end else begin
            tx1_rd_q  <= tx1_rd_d;
            tx1_own_q <= tx1_own_d;
            ty1_rd_q  <= ty1_rd_d;
            ty1_own_q <= ty1_own_d;
            tx2_rd_q  <= tx1_rd_q;
            tx2_own_q <= tx1_own_q;
            ty2_rd_q  <= ty1_rd_q;
            ty2_own_q <= ty1_own_q;
        end
    end

    // Registered read-data return to the owning requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt        = gnt_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign ram_addr_x = addr_x_q;
    assign ram_addr_y = addr_y_q;
    assign ram_data_x = data_x_q;
    assign ram_data_y = data_y_q;
    assign ram_we_x   = we_x_q;
    assign ram_we_y   = we_y_q;

endmodule

// File: tb/tb_dualram_arbiter.sv
// Self-checking bench for dualram_arbiter: directed scenarios plus a random
// run compared against a transaction-level model of the arbitration rules.

module tb_dualram_arbiter;

    localparam int W    = 16;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req, req_we, gnt, rvalid;
    logic [NREQ*W-1:0] req_addr, req_wdata, rdata;
    logic [W-1:0]      ram_addr_x, ram_addr_y, ram_data_x, ram_data_y;
    logic              ram_we_x, ram_we_y;
    logic [W-1:0]      ram_q_x, ram_q_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dualram_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr_x(ram_addr_x), .ram_addr_y(ram_addr_y),
        .ram_data_x(ram_data_x), .ram_data_y(ram_data_y),
        .ram_we_x(ram_we_x), .ram_we_y(ram_we_y),
        .ram_q_x(ram_q_x), .ram_q_y(ram_q_y)
    );

    // Dual-port RAM with registered, read-first outputs.
    logic [W-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (ram_we_x) ram[ram_addr_x] <= ram_data_x;
        if (ram_we_y) ram[ram_addr_y] <= ram_data_y;
        ram_q_x <= ram[ram_addr_x];
        ram_q_y <= ram[ram_addr_y];
    end

    function automatic logic [15:0] init_val(input int a);
        return 16'(a) ^ 16'hC3C3;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          idx;
        logic [15:0] data;
    } rd_t;

    logic [15:0] m_mem [0:65535];
    rd_t         m_q[$];
    logic [3:0]  m_prev_gnt;
    int          m_ptr;
    int          m_edge;
    logic [3:0]  exp_gnt, exp_rvalid;
    logic [15:0] exp_rdata [NREQ];
    logic [15:0] exp_ax, exp_ay, exp_dx, exp_dy;
    logic        exp_wx, exp_wy;

    function automatic logic [15:0] addr_of(input int i);
        return req_addr[i*W +: W];
    endfunction

    function automatic logic [15:0] wdata_of(input int i);
        return req_wdata[i*W +: W];
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_prev_gnt = 4'b0;
        m_ptr      = 0;
        exp_gnt    = 4'b0;
        exp_rvalid = 4'b0;
        exp_ax = 16'h0; exp_ay = 16'h0; exp_dx = 16'h0; exp_dy = 16'h0;
        exp_wx = 1'b0;  exp_wy = 1'b0;
        for (int i = 0; i < NREQ; i++) exp_rdata[i] = 16'h0;
    endtask

    // One arbitration edge, using the inputs that were present at that edge.
    task automatic model_step();
        int         hits[$];
        int         a, b, last;
        logic [3:0] elig;
        m_edge++;
        exp_rvalid = 4'b0;
        for (int k = m_q.size() - 1; k >= 0; k--) begin
            if (m_q[k].due == m_edge) begin
                exp_rvalid[m_q[k].idx] = 1'b1;
                exp_rdata[m_q[k].idx]  = m_q[k].data;
                m_q.delete(k);
            end
        end
        elig = req & ~m_prev_gnt;
        for (int k = 0; k < NREQ; k++) begin
            if (elig[(m_ptr + k) % NREQ]) hits.push_back((m_ptr + k) % NREQ);
        end
        exp_gnt = 4'b0;
        exp_wx  = 1'b0;
        exp_wy  = 1'b0;
        last    = -1;
        if (hits.size() >= 1) begin
            a = hits[0];
            exp_gnt[a] = 1'b1;
            exp_ax = addr_of(a); exp_dx = wdata_of(a); exp_wx = req_we[a];
            if (req_we[a]) m_mem[addr_of(a)] = wdata_of(a);
            else m_q.push_back('{m_edge + 2, a, m_mem[addr_of(a)]});
            last = a;
            if (hits.size() >= 2) begin
                b = hits[1];
                if (!((addr_of(a) == addr_of(b)) && (req_we[a] || req_we[b]))) begin
                    exp_gnt[b] = 1'b1;
                    exp_ay = addr_of(b); exp_dy = wdata_of(b); exp_wy = req_we[b];
                    if (req_we[b]) m_mem[addr_of(b)] = wdata_of(b);
                    else m_q.push_back('{m_edge + 2, b, m_mem[addr_of(b)]});
                    last = b;
                end
            end
        end
        if (last >= 0) m_ptr = (last + 1) % NREQ;
        m_prev_gnt = exp_gnt;
    endtask

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
        if (rst_n) model_step();
        else m_reset();
    endtask

    task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*W +: W]  = a;
        req_wdata[i*W +: W] = d;
    endtask

    task automatic clr_req(input int i);
        req[i]    = 1'b0;
        req_we[i] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        checks++;
        if ({gnt, rvalid, rdata, ram_addr_x, ram_addr_y, ram_data_x, ram_data_y, ram_we_x, ram_we_y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h ax=%h ay=%h wx=%b wy=%b, all required 0",
                     gnt, rvalid, rdata, ram_addr_x, ram_addr_y, ram_we_x, ram_we_y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 16'd5, 16'd0);
        cyc();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        checks++;
        if ({ram_addr_x, ram_we_x, ram_we_y} !== {16'd5, 1'b0, 1'b0}) begin
            errors++; $display("FAIL single_port: addr_x=%0d we_x=%b we_y=%b want 5 0 0", ram_addr_x, ram_we_x, ram_we_y);
        end
        clr_req(0);
        cyc();
        checks++;
        if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_early_rvalid: got %b want 0000", rvalid); end
        cyc();
        checks++;
        if (rvalid !== 4'b0001 || rdata[15:0] !== 16'd1) begin
            errors++; $display("FAIL single_rdata: rvalid=%b rdata0=%h want 0001 0001", rvalid, rdata[15:0]);
        end
    endtask

    task automatic test_write_then_read();
        set_req(0, 1'b1, 16'd7, 16'h00AB);
        cyc();
        checks++;
        if ({gnt, ram_we_x, ram_addr_x, ram_data_x} !== {4'b0001, 1'b1, 16'd7, 16'h00AB}) begin
            errors++; $display("FAIL wr_grant: gnt=%b we_x=%b ax=%h dx=%h want 0001 1 0007 00ab", gnt, ram_we_x, ram_addr_x, ram_data_x);
        end
        set_req(0, 1'b0, 16'd7, 16'd0);
        cyc();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL wr_mask: gnt=%b want 0000", gnt); end
        cyc();
        checks++;
        if ({gnt, ram_we_x, ram_addr_x} !== {4'b0001, 1'b0, 16'd7}) begin
            errors++; $display("FAIL rd_grant: gnt=%b we_x=%b ax=%h want 0001 0 0007", gnt, ram_we_x, ram_addr_x);
        end
        cyc();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL rd_mask: gnt=%b want 0000", gnt); end
        clr_req(0);
        cyc();
        checks++;
        if (rvalid !== 4'b0001 || rdata[15:0] !== 16'h00AB) begin
            errors++; $display("FAIL wr_rd_data: rvalid=%b rdata0=%h want 0001 00ab", rvalid, rdata[15:0]);
        end
    endtask

    task automatic test_four_reads();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 16'(10 + i), 16'd0);
        cyc();
        checks++;
        if ({gnt, ram_addr_x, ram_addr_y, ram_we_x, ram_we_y} !== {4'b0011, 16'd10, 16'd11, 2'b00}) begin
            errors++; $display("FAIL four_edge1: gnt=%b ax=%0d ay=%0d want 0011 10 11", gnt, ram_addr_x, ram_addr_y);
        end
        cyc();
        checks++;
        if ({gnt, ram_addr_x, ram_addr_y, ram_we_x, ram_we_y} !== {4'b1100, 16'd12, 16'd13, 2'b00}) begin
            errors++; $display("FAIL four_edge2: gnt=%b ax=%0d ay=%0d want 1100 12 13", gnt, ram_addr_x, ram_addr_y);
        end
        for (int i = 0; i < NREQ; i++) clr_req(i);
        cyc();
        checks++;
        if (rvalid !== 4'b0011 || rdata[15:0] !== init_val(10) || rdata[31:16] !== init_val(11)) begin
            errors++; $display("FAIL four_rv01: rvalid=%b r0=%h r1=%h want 0011 %h %h", rvalid, rdata[15:0], rdata[31:16], init_val(10), init_val(11));
        end
        cyc();
        checks++;
        if (rvalid !== 4'b1100 || rdata[47:32] !== init_val(12) || rdata[63:48] !== init_val(13)) begin
            errors++; $display("FAIL four_rv23: rvalid=%b r2=%h r3=%h want 1100 %h %h", rvalid, rdata[47:32], rdata[63:48], init_val(12), init_val(13));
        end
    endtask

    task automatic test_hazard();
        set_req(0, 1'b1, 16'd20, 16'h1234);
        set_req(1, 1'b0, 16'd20, 16'd0);
        cyc();
        checks++;
        if ({gnt, ram_we_x, ram_addr_x, ram_we_y} !== {4'b0001, 1'b1, 16'd20, 1'b0}) begin
            errors++; $display("FAIL hazard_edge1: gnt=%b we_x=%b ax=%0d we_y=%b want 0001 1 20 0", gnt, ram_we_x, ram_addr_x, ram_we_y);
        end
        clr_req(0);
        cyc();
        checks++;
        if ({gnt, ram_we_x, ram_addr_x} !== {4'b0010, 1'b0, 16'd20}) begin
            errors++; $display("FAIL hazard_edge2: gnt=%b we_x=%b ax=%0d want 0010 0 20", gnt, ram_we_x, ram_addr_x);
        end
        clr_req(1);
        cyc();
        cyc();
        checks++;
        if (rvalid !== 4'b0010 || rdata[31:16] !== 16'h1234) begin
            errors++; $display("FAIL hazard_rdata: rvalid=%b r1=%h want 0010 1234", rvalid, rdata[31:16]);
        end
    endtask

    task automatic test_read_read();
        set_req(2, 1'b0, 16'd30, 16'd0);
        set_req(3, 1'b0, 16'd30, 16'd0);
        cyc();
        checks++;
        if ({gnt, ram_addr_x, ram_addr_y} !== {4'b1100, 16'd30, 16'd30}) begin
            errors++; $display("FAIL rr_grant: gnt=%b ax=%0d ay=%0d want 1100 30 30", gnt, ram_addr_x, ram_addr_y);
        end
        clr_req(2);
        clr_req(3);
        cyc();
        cyc();
        checks++;
        if (rvalid !== 4'b1100 || rdata[47:32] !== init_val(30) || rdata[63:48] !== init_val(30)) begin
            errors++; $display("FAIL rr_rdata: rvalid=%b r2=%h r3=%h want 1100 %h", rvalid, rdata[47:32], rdata[63:48], init_val(30));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cyc();
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt edge=%0d: got %b want %b", m_edge, gnt, exp_gnt); end
            checks++;
            if ({ram_addr_x, ram_we_x, ram_addr_y, ram_we_y} !== {exp_ax, exp_wx, exp_ay, exp_wy}) begin
                errors++; $display("FAIL rnd_port edge=%0d: x=%h/%b y=%h/%b want x=%h/%b y=%h/%b", m_edge,
                                   ram_addr_x, ram_we_x, ram_addr_y, ram_we_y, exp_ax, exp_wx, exp_ay, exp_wy);
            end
            if (exp_wx) begin
                checks++;
                if (ram_data_x !== exp_dx) begin errors++; $display("FAIL rnd_data_x edge=%0d: got %h want %h", m_edge, ram_data_x, exp_dx); end
            end
            if (exp_wy) begin
                checks++;
                if (ram_data_y !== exp_dy) begin errors++; $display("FAIL rnd_data_y edge=%0d: got %h want %h", m_edge, ram_data_y, exp_dy); end
            end
            checks++;
            if (rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid edge=%0d: got %b want %b", m_edge, rvalid, exp_rvalid); end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rvalid[i]) begin
                    checks++;
                    if (rdata[i*W +: W] !== exp_rdata[i]) begin
                        errors++; $display("FAIL rnd_rdata edge=%0d req=%0d: got %h want %h", m_edge, i, rdata[i*W +: W], exp_rdata[i]);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || gnt[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'($urandom_range(0, 1)), 16'(100 + $urandom_range(0, 3)), 16'($urandom));
                    else
                        clr_req(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) clr_req(i);
        repeat (4) cyc();
    endtask

    task automatic test_fairness();
        int wt [NREQ];
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
        set_req(0, 1'b0, 16'd40, 16'd0);
        for (int n = 0; n < 60; n++) begin
            cyc();
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL fair_gnt edge=%0d: got %b want %b", m_edge, gnt, exp_gnt); end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        checks++;
                        if (wt[i] + 1 > 3) begin
                            errors++; $display("FAIL fair_wait req=%0d: waited %0d cycles, limit 3", i, wt[i] + 1);
                        end
                        wt[i] = 0;
                    end else begin
                        wt[i]++;
                    end
                end
            end
            for (int i = 1; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 1) != 0) set_req(i, 1'b0, 16'(40 + i), 16'd0);
                end else if (gnt[i]) begin
                    if ($urandom_range(0, 1) != 0) begin clr_req(i); wt[i] = 0; end
                end
            end
        end
        for (int i = 0; i < NREQ; i++) clr_req(i);
        repeat (4) cyc();
    endtask

    task automatic test_reset_midop();
        set_req(0, 1'b1, 16'd60, 16'hBEEF);
        set_req(1, 1'b0, 16'd50, 16'd0);
        cyc();
        checks++;
        if (gnt !== 4'b0011) begin errors++; $display("FAIL midop_gnt: got %b want 0011", gnt); end
        clr_req(0);
        clr_req(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rvalid, rdata, ram_addr_x, ram_addr_y, ram_data_x, ram_data_y, ram_we_x, ram_we_y} !== '0) begin
            errors++; $display("FAIL midop_async_clear: gnt=%b rvalid=%b we_x=%b we_y=%b ax=%h ay=%h, all required 0",
                               gnt, rvalid, ram_we_x, ram_we_y, ram_addr_x, ram_addr_y);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            checks++;
            if (rvalid !== 4'b0000) begin errors++; $display("FAIL midop_rvalid: got %b want 0000", rvalid); end
        end
        checks++;
        if (ram[60] !== init_val(60)) begin
            errors++; $display("FAIL midop_write_dropped: ram[60]=%h want %h", ram[60], init_val(60));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_edge    = 0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]   = init_val(a);
            m_mem[a] = init_val(a);
        end
        ram[5]   = 16'd1;
        m_mem[5] = 16'd1;
        m_reset();

        test_reset();
        test_single_read();
        test_write_then_read();
        test_four_reads();
        test_hazard();
        test_read_read();
        test_random();
        test_fairness();
        test_reset_midop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dualram_arbiter.md
Name: dualram_arbiter

Overview:
- Shares the two ports (X, Y) of the mem Y dual-port RAM among NREQ requesters.
- Each cycle it grants up to two requests with round-robin fairness: the first goes to port X, the second to port Y.
- Same-address hazards are serialised.
- It drives registered RAM port signals and returns read data to the requester that issued the read.

Parameters:
- W, 16, data width and address width (RAM address bus is W bits).
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester request; held with we/addr/wdata stable until the gnt pulse.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*W  flattened addresses; requester i at bits [i*W +: W].
- req_wdata  in  NREQ*W  flattened write data.
- gnt  out  NREQ  one-cycle grant pulse per requester.
- rvalid  out  NREQ  one-cycle read-data-valid pulse per requester.
- rdata  out  NREQ*W  flattened read data; meaningful only while rvalid[i] is high.
- ram_addr_x, ram_addr_y  out  W  RAM port addresses.
- ram_data_x, ram_data_y  out  W  RAM write data.
- ram_we_x, ram_we_y  out  1  RAM write enables; always 0 or 1, never z.
- ram_q_x, ram_q_y  in  W  RAM registered read data.

Behaviour:
- Reset (async, rst_n low): gnt, rvalid, rdata, ram_addr_*, ram_data_*, ram_we_* all 0; rr_ptr = 0; in-flight tracking cleared.
- Eligible set at posedge T: req[i] = 1 and i not granted at posedge T-1. This masks the stale request in the cycle after a grant, so each requester gets at most one grant per 2 cycles.
- Selection: scan eligible requesters starting at rr_ptr, ascending modulo NREQ.
  - First hit A → port X.
  - Second hit B → port Y, unless addr(A) == addr(B) and req_we[A] | req_we[B]. In that case B is not granted this cycle and stays pending.
  - Read-read to the same address is allowed.
- At posedge T:
  - gnt[A] (and gnt[B]) = 1 for one cycle.
  - ram_*_x loaded from A; ram_*_y loaded from B.
  - An idle port loads we = 0 and keeps its address (a harmless read).
- rr_ptr update: becomes (last granted index + 1) mod NREQ; unchanged if nothing was granted.
- RAM executes the operation at posedge T+1. For reads, ram_q_* is valid after T+1.
- Read return:
  - At posedge T+2, the arbiter captures q_x into rdata[A] and q_y into rdata[B], and pulses rvalid for one cycle.
  - Read latency is gnt edge + 2.
  - Writes produce no rvalid.
- Port tags (owner index, is-read) are pipelined 2 stages alongside each port, so back-to-back grants every cycle are supported.
- No starvation: a pending eligible requester is granted within ceil(NREQ/2)+1 cycles, excluding hazard deferrals. A deferred requester becomes the head of the next scan because rr_ptr points past A.
- Simultaneous write to the same address through both ports is impossible by construction.
- Reset mid-operation:
  - In-flight reads are dropped with no rvalid.
  - A write is committed only if rst_n stays high through its RAM execute edge (T+1).
- Requester changing req/addr before gnt is a protocol violation; behaviour is undefined.

Test Plan:
- Reset, then single read: req[0] = 1, addr = 5, RAM preloaded 1 → gnt[0] at edge 1, ram_addr_x = 5 with we_x = 0, rvalid[0] at edge 3 with rdata[0] = 1.
- Write then read: req0 writes 0x00AB to addr 7; after gnt, req0 reads addr 7 → rvalid[0] with rdata = 0x00AB. No grant to req0 in the cycle immediately after either gnt.
- All 4 requesters reading distinct addresses 10..13 concurrently:
  - Edge 1: gnt[0] on X, gnt[1] on Y. Edge 2: gnt[2] on X, gnt[3] on Y.
  - rvalid pairs follow 2 cycles after each grant with correct data.
- Hazard: req0 writes addr 20 = 0x1234 while req1 reads addr 20 in the same cycle → only gnt[0]; gnt[1] next edge; req1's rdata = 0x1234.
- Read-read same address: req2 and req3 both read addr 30 → both granted the same edge, both rvalid with identical data.
- Fairness: req0 held continuously, req1..3 toggled → no requester waits more than 3 cycles. Pull rst_n low between gnt and rvalid → no rvalid, all outputs 0 immediately.
